// File: rtl/ysyx_operand_fetch.sv
// Operand fetch with a busy scoreboard: reads sources, stalls on RAW/WAW hazards, issues operands to execute.
// Latency: 1 cycle from an accepted decoded instruction to out_valid with registered operands.
// Backpressure: in_ready drops while the output holds an unaccepted payload or any hazard exists; payload held stable.
//
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid/in_ready           - decoded-instruction handshake (in_rs1, in_rs2, in_rd, in_rd_wen)
//   raddr1/2, rdata1/2          - combinational register-file read ports
//   wb_en, wb_addr, wb_data     - mirror of the register-file write port (clears scoreboard bits)
//   out_valid/out_ready         - operand handshake (out_rs1_val, out_rs2_val, out_rd, out_rd_wen)
//   stall_cnt                   - free-running count of cycles an offered instruction was held by a hazard
//
// Build option: define YSYX_OPF_BYPASS_EN to forward same-cycle writeback data to a waiting source.

module ysyx_operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    output logic [4:0]  raddr1,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic [31:0] stall_cnt
);

`ifdef YSYX_OPF_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [31:0] busy_q,      busy_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] rs1_val_q,   rs1_val_d;
    logic [31:0] rs2_val_q,   rs2_val_d;
    logic [4:0]  rd_q,        rd_d;
    logic        rd_wen_q,    rd_wen_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic byp1, byp2, haz1, haz2, waw, any_hazard, issue;
    logic [31:0] op1, op2;

    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;

    always_comb begin
        // Forwarding only exists in the bypass build; the constant folds the path away otherwise.
        byp1 = BYPASS_EN && wb_en && (wb_addr == in_rs1);
        byp2 = BYPASS_EN && wb_en && (wb_addr == in_rs2);

        haz1 = (in_rs1 != 5'd0) && busy_q[in_rs1] && !byp1;
        haz2 = (in_rs2 != 5'd0) && busy_q[in_rs2] && !byp2;
        // A writeback to the destination in the same cycle retires the older write, so a new
        // write to the same register may proceed in either build.
        waw  = in_rd_wen && (in_rd != 5'd0) && busy_q[in_rd]
               && !(wb_en && (wb_addr == in_rd));
        any_hazard = haz1 || haz2 || waw;

        in_ready = (!out_valid_q || out_ready) && !any_hazard;
        issue    = in_valid && in_ready;

        op1 = (in_rs1 == 5'd0) ? 32'd0 : (byp1 ? wb_data : rdata1);
        op2 = (in_rs2 == 5'd0) ? 32'd0 : (byp2 ? wb_data : rdata2);

        // Clear before set so a same-index set wins.
        busy_d = busy_q;
        if (wb_en && (wb_addr != 5'd0)) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue && in_rd_wen && (in_rd != 5'd0)) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        out_valid_d = out_valid_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        rd_d        = rd_q;
        rd_wen_d    = rd_wen_q;
        if (issue) begin
            out_valid_d = 1'b1;
            rs1_val_d   = op1;
            rs2_val_d   = op2;
            rd_d        = in_rd;
            rd_wen_d    = in_rd_wen;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (in_valid && any_hazard) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            rd_q        <= rd_d;
            rd_wen_q    <= rd_wen_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_rd      = rd_q;
    assign out_rd_wen  = rd_wen_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/ysyx_operand_fetch.md
YSYX_OPERAND_FETCH -- requirements
Module: ysyx_operand_fetch

Interface
REQ-001 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset), listed first.
REQ-002 SHALL have in_valid (in, 1) and in_ready (out, 1): decoded-instruction handshake.
REQ-003 SHALL have in_rs1 and in_rs2 (in, 5 each): source register indices.
REQ-004 SHALL have in_rd (in, 5) and in_rd_wen (in, 1): destination index and the instruction's write intent.
REQ-005 SHALL have raddr1 and raddr2 (out, 5 each) and rdata1 and rdata2 (in, 32 each): combinational register-file read ports.
REQ-006 SHALL have wb_en (in, 1), wb_addr (in, 5) and wb_data (in, 32), which mirror the register-file write port.
REQ-007 SHALL have out_valid (out, 1) and out_ready (in, 1): operand handshake to execute.
REQ-008 SHALL have out_rs1_val and out_rs2_val (out, 32 each), out_rd (out, 5) and out_rd_wen (out, 1).
REQ-009 SHALL have stall_cnt (out, 32): count of hazard-stall cycles.

Function
REQ-010 SHALL drive raddr1 = in_rs1 and raddr2 = in_rs2 combinationally at all times.
REQ-011 SHALL keep a 32-bit busy scoreboard; bit 0 SHALL always read 0.
REQ-012 Source hazard: in_rsN != 0 and busy[in_rsN] = 1, and the bypass clear condition (REQ-013) does not hold.
REQ-013 Bypass clear condition (bypass build only): wb_en = 1 and wb_addr = in_rsN.
REQ-014 WAW hazard: in_rd_wen = 1, in_rd != 0 and busy[in_rd] = 1, unless wb_en = 1 and wb_addr = in_rd in the same cycle; this exception applies in both builds.
REQ-015 in_ready SHALL equal (!out_valid || out_ready) && !any_hazard; it is combinational and independent of in_valid.
REQ-016 Issue SHALL occur when in_valid && in_ready; out_* SHALL be registered at that edge, giving 1-cycle latency.
REQ-017 Operand value at issue: 0 if index is 0; else wb_data if the bypass condition holds; else rdata.
REQ-018 On issue with in_rd_wen && in_rd != 0, busy[in_rd] SHALL be set.
REQ-019 When wb_en && wb_addr != 0, busy[wb_addr] SHALL be cleared.
REQ-020 If set and clear target the same index in one cycle, set SHALL win.
REQ-021 out_valid SHALL be set on issue, cleared on out_ready without a new issue, and held otherwise.
REQ-022 out_* SHALL remain stable while out_valid && !out_ready.
REQ-023 A simultaneous output accept and new issue SHALL keep out_valid = 1 with the new payload loaded.
REQ-024 stall_cnt SHALL increment by 1 each cycle in which in_valid && any_hazard; it wraps from 0xFFFFFFFF to 0.
REQ-025 in_rd_wen = 1 with in_rd = 0 SHALL issue normally and SHALL NOT change the scoreboard.

Reset
REQ-026 When rst = 1 at a rising edge: busy, out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_wen and stall_cnt SHALL all become 0.
REQ-027 Reset SHALL take priority over any concurrent issue, writeback or count; in-flight scoreboard state SHALL be discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts (no pending output, no hazards).

Configuration
REQ-029 Macro YSYX_OPF_BYPASS_EN defined: REQ-013 and the wb_data path of REQ-017 SHALL be active, so a source matching same-cycle writeback issues with wb_data.
REQ-030 Macro YSYX_OPF_BYPASS_EN undefined: no forwarding; a busy source SHALL stall through the writeback cycle and issue the following cycle from rdata.

Verification
REQ-031 After reset: issue rs1=0, rs2=0, rdata1=rdata2=0xDEADBEEF -> out_rs1_val=out_rs2_val=0, out_valid=1 one cycle later.
REQ-032 Issue rd=5, wen=1; next instruction rs1=5, held 3 cycles; then wb_en=1, wb_addr=5, wb_data=0x12345678 -> bypass build: issue in the wb cycle with out_rs1_val=0x12345678 and stall_cnt=3; non-bypass build: issue one cycle later and stall_cnt=4.
REQ-033 out_ready=0 for 4 cycles with out_valid=1 -> payload stable, in_ready=0, stall_cnt unchanged.
REQ-034 Same-cycle issue of rd=7 and wb to 7 (rd=7 was busy) -> WAW exception allows issue and busy[7] remains 1 afterward.
REQ-035 Assert rst while busy[3]=1 and out_valid=1 -> next cycle all outputs 0, busy clear, and rs1=3 issues without stall.
REQ-036 Preload stall_cnt=0xFFFFFFFF (force) and stall one cycle -> stall_cnt=0.
